// File: rtl/sd_dac_multi_pkg.sv
// Shared constants and types for the multi-channel sigma-delta DAC.
// Integrator guard width and the modulator order selector.
package sd_dac_multi_pkg;

  localparam int GUARD = 4;

  typedef enum logic {
    ORDER1 = 1'b0,
    ORDER2 = 1'b1
  } order_e;

endpackage

// File: rtl/sd_mod_ch.sv
// One sigma-delta modulator channel: first order (carry of a phase
// accumulator) or second order (two saturating integrators).
module sd_mod_ch
  import sd_dac_multi_pkg::*;
#(
  parameter int BITDEPTH = 16
) (
  input  logic                sample_clock,
  input  logic                rst,
  input  logic                clr,
  input  order_e              mode,
  input  logic                mute,
  input  logic [BITDEPTH-1:0] x,
  output logic                out
);

  localparam int IW = BITDEPTH + GUARD;
  localparam int SW = IW + 2;
  localparam logic signed [SW-1:0] SAT = SW'(64'sd1 <<< (BITDEPTH + 2));
  localparam logic signed [SW-1:0] FB  = SW'(64'sd1 <<< (BITDEPTH - 1));

  logic signed [BITDEPTH-1:0] xm;
  logic        [BITDEPTH-1:0] u;
  logic        [BITDEPTH:0]   acc;
  logic        [BITDEPTH:0]   acc_n;
  logic signed [IW-1:0]       i1;
  logic signed [IW-1:0]       i2;
  logic signed [IW-1:0]       i1_n;
  logic signed [IW-1:0]       i2_n;
  logic signed [SW-1:0]       xs;
  logic signed [SW-1:0]       fb;
  logic signed [SW-1:0]       s1;
  logic signed [SW-1:0]       s2;
  logic                       q2;

  function automatic logic signed [IW-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > SAT) return IW'(SAT);
    if (v < -SAT) return IW'(-SAT);
    return IW'(v);
  endfunction

  assign xm = mute ? '0 : $signed(x);
  // Offset-binary view of the sample drives the phase accumulator.
  assign u  = {~xm[BITDEPTH-1], xm[BITDEPTH-2:0]};
  assign acc_n = {1'b0, acc[BITDEPTH-1:0]} + {1'b0, u};

  assign xs = SW'(xm);
  assign fb = q2 ? FB : -FB;
  assign s1 = SW'(i1) + xs - fb;
  assign i1_n = sat(s1);
  // Second stage integrates the freshly updated first stage.
  assign s2 = SW'(i2) + SW'(i1_n) - fb;
  assign i2_n = sat(s2);

  assign out = (mode == ORDER2) ? q2 : acc[BITDEPTH];

  always_ff @(posedge sample_clock) begin
    if (rst || clr) begin
      acc <= '0;
      i1  <= '0;
      i2  <= '0;
      q2  <= 1'b0;
    end else if (mode == ORDER2) begin
      i1 <= i1_n;
      i2 <= i2_n;
      q2 <= ~i2_n[IW-1];
    end else begin
      acc <= acc_n;
    end
  end

endmodule

// File: rtl/sd_dac_multi.sv
// Multi-channel sigma-delta DAC: frame staging, oversampling
// counter and handshake in front of per-channel modulators.
module sd_dac_multi
  import sd_dac_multi_pkg::*;
#(
  parameter int BITDEPTH = 16,
  parameter int CHANNELS = 2,
  parameter int OSR_LOG2 = 8
) (
  input  logic                         sample_clock,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITDEPTH-1:0] in_pcm,
  input  logic                         order2,
  input  logic                         mute,
  output logic [CHANNELS-1:0]          out,
  output logic                         frame_tick,
  output logic                         underrun
);

  logic [OSR_LOG2-1:0]          cnt;
  logic                         full;
  logic [CHANNELS*BITDEPTH-1:0] staged;
  logic [CHANNELS*BITDEPTH-1:0] active;
  order_e                       ord_q;
  order_e                       ord_d;
  logic                         clr;
  logic                         accept;

  assign frame_tick = !rst && (&cnt);
  assign underrun   = frame_tick && !full;
  assign in_ready   = !full && !rst;
  assign accept     = in_valid && in_ready;
  // Mode switch restarts every modulator from a clean state.
  assign clr        = (ord_q != ord_d);

  always_ff @(posedge sample_clock) begin
    if (rst) begin
      cnt    <= '0;
      full   <= 1'b0;
      staged <= '0;
      active <= '0;
      ord_q  <= ORDER1;
      ord_d  <= ORDER1;
    end else begin
      cnt   <= cnt + OSR_LOG2'(1);
      ord_q <= order_e'(order2);
      ord_d <= ord_q;
      if (frame_tick && full) begin
        active <= staged;
        full   <= 1'b0;
      end
      if (accept) begin
        staged <= in_pcm;
        full   <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    sd_mod_ch #(
      .BITDEPTH(BITDEPTH)
    ) u_mod (
      .sample_clock(sample_clock),
      .rst         (rst),
      .clr         (clr),
      .mode        (ord_q),
      .mute        (mute),
      .x           (active[g*BITDEPTH +: BITDEPTH]),
      .out         (out[g])
    );
  end

endmodule
